// File: rtl/eeprom_pkg.sv
// Shared types and defaults for the EEPROM arbiter.
// Holds FSM encodings, timing defaults and counter sizing.
package eeprom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF = 4096;
  localparam int TWR_DEF     = 10000;

  // Bits needed to count up to the larger of the two limits
  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/eeprom_rr2.sv
// Two-way round-robin grant with a priority pointer.
// Grant is combinational; the pointer moves on an accepted grant.
module eeprom_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt1,
  output logic any
);

  logic prio;

  // Requester 1 wins if alone or if it holds priority
  always_comb begin
    any  = req0 | req1;
    gnt1 = req1 & (~req0 | prio);
  end

  // After a grant, favour the requester that did not get it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (take && any) begin
      prio <= ~gnt1;
    end
  end

endmodule

// File: rtl/eeprom_arb.sv
// Two-requester arbiter in front of a serial EEPROM engine.
// Handles timeout abort and post-write guard time.
import eeprom_pkg::*;

module eeprom_arb #(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int TWR_CYC     = TWR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req0,
  input  logic        req1,
  input  logic        rnw0,
  input  logic        rnw1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  rdata,
  output logic        eng_wr,
  output logic        eng_rd,
  output logic [10:0] eng_addr,
  output logic [7:0]  eng_wdata,
  output logic        eng_data_oe,
  input  logic [7:0]  eng_rdata,
  input  logic        eng_ack,
  output logic        busy
);

  localparam int CW = cnt_bits(TIMEOUT_CYC, TWR_CYC);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] GD_LAST =
    CW'((TWR_CYC > 0) ? TWR_CYC - 1 : 0);
  localparam logic GUARD_EN = (TWR_CYC > 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          gnt_r;
  logic          rnw_r;
  logic          gnt1;
  logic          any;
  logic          sel_rnw;
  logic [10:0]   sel_addr;
  logic [7:0]    sel_wdata;

  eeprom_rr2 u_rr2 (
    .clk   (CLK),
    .rst_n (RESET),
    .req0  (req0),
    .req1  (req1),
    .take  (state == ST_IDLE),
    .gnt1  (gnt1),
    .any   (any)
  );

  // Fields of the requester the round-robin picked
  always_comb begin
    sel_rnw   = gnt1 ? rnw1   : rnw0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gnt_r       <= 1'b0;
      rnw_r       <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata       <= '0;
      eng_wr      <= 1'b0;
      eng_rd      <= 1'b0;
      eng_addr    <= '0;
      eng_wdata   <= '0;
      eng_data_oe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt_r       <= gnt1;
            rnw_r       <= sel_rnw;
            eng_addr    <= sel_addr;
            eng_wdata   <= sel_wdata;
            eng_rd      <= sel_rnw;
            eng_wr      <= ~sel_rnw;
            eng_data_oe <= ~sel_rnw;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (eng_ack || cnt == TO_LAST) begin
            eng_wr      <= 1'b0;
            eng_rd      <= 1'b0;
            eng_data_oe <= 1'b0;
            if (eng_ack && rnw_r) rdata <= eng_rdata;
            done0 <= ~gnt_r;
            done1 <= gnt_r;
            err0  <= ~gnt_r & ~eng_ack;
            err1  <= gnt_r & ~eng_ack;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cnt <= '0;
          if (!rnw_r && !(err0 | err1) && GUARD_EN) begin
            state <= ST_GUARD;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_GUARD: begin
          if (cnt == GD_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/eeprom_arb.md
EEPROM_ARB -- requirements
Module: eeprom_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, 4096, maximum number of cycles to wait for eng_ack before the transaction is aborted.
REQ-002 Parameter: TWR_CYC, 10000, guard cycles after every completed write (EEPROM internal write time).
REQ-003 Port: CLK  input  1  single clock; all logic on posedge.
REQ-004 Port: RESET  input  1  synchronous, active-low reset.
REQ-005 Port: req0, req1  input  1 each  requester transaction request; held high until the matching done pulse.
REQ-006 Port: rnw0, rnw1  input  1 each  1=read, 0=write.
REQ-007 Port: addr0, addr1  input  11 each  EEPROM byte address.
REQ-008 Port: wdata0, wdata1  input  8 each  write data.
REQ-009 Port: done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 Port: err0, err1  output  1 each  valid with done; 1 = timeout abort.
REQ-011 Port: rdata  output  8  read data, valid in the done cycle and held until the next read completes.
REQ-012 Port: eng_wr, eng_rd  output  1 each  write/read strobes to the serial EEPROM engine.
REQ-013 Port: eng_addr  output  11  address to the engine.
REQ-014 Port: eng_wdata  output  8  write data to the engine.
REQ-015 Port: eng_data_oe  output  1  1 while a write is in progress; drives the top-level tristate of the engine data bus.
REQ-016 Port: eng_rdata  input  8  engine read data.
REQ-017 Port: eng_ack  input  1  engine end-of-cycle acknowledge.
REQ-018 Port: busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY, DONE and GUARD.
REQ-020 In IDLE, sampling any req high at edge k SHALL latch that requester's rnw, addr and wdata and enter BUSY at k+1.
REQ-021 In BUSY, eng_wr (write) or eng_rd (read) SHALL be held high continuously; only one of the two is ever high.
REQ-022 eng_addr, eng_wdata and eng_data_oe SHALL remain stable for the whole of BUSY.
REQ-023 When eng_ack is sampled high in BUSY, the FSM SHALL capture eng_rdata (reads only), drop both strobes and enter DONE.
REQ-024 In DONE, done<granted> SHALL be high for exactly one cycle, with err low.
REQ-025 Round-robin arbitration: when both requests are high in IDLE, the grant SHALL go to the requester not granted last.
REQ-026 After reset, the round-robin priority SHALL favour requester 0.
REQ-027 If BUSY lasts TIMEOUT_CYC cycles without eng_ack, the FSM SHALL drop the strobes and enter DONE with err=1.
REQ-028 rdata SHALL be unchanged on a timeout abort.
REQ-029 DONE SHALL go to GUARD after a write that was acknowledged (err=0) when TWR_CYC>0; otherwise DONE SHALL go to IDLE.
REQ-030 GUARD SHALL last exactly TWR_CYC cycles and then return to IDLE; requests are not granted during GUARD.
REQ-031 A requester dropping req mid-transaction SHALL NOT abort it; its done pulse is still issued.
REQ-032 A req still high in the cycle after its done pulse SHALL be treated as a new request.
REQ-033 An eng_ack arriving outside BUSY SHALL be ignored.
REQ-034 The timeout and guard counters SHALL be sized to hold max(TIMEOUT_CYC, TWR_CYC) and SHALL never wrap.

Reset
REQ-035 While RESET=0 at a clock edge, the FSM SHALL enter IDLE and all outputs (strobes, done, err, busy, eng_data_oe, rdata, eng_addr, eng_wdata) SHALL be 0.
REQ-036 Reset SHALL also clear the counters and set the priority to requester 0, including when asserted mid-BUSY or mid-GUARD.

Structure
REQ-037 FSM state encodings and the default values of TIMEOUT_CYC and TWR_CYC SHALL live in the shared package eeprom_pkg.
REQ-038 One sub-module, eeprom_rr2 (2-way round-robin grant with priority pointer), SHALL be used; everything else stays flat.

Verification
REQ-039 Single write: req0 with addr=11'h123 and wdata=8'hA5 -> eng_wr rises 1 cycle later; eng_ack -> done0 for 1 cycle, err0=0, then busy held for TWR_CYC cycles.
REQ-040 Read: req1 with addr=11'h7FF, engine returns 8'h3C -> done1 pulse with rdata=8'h3C and no GUARD.
REQ-041 Contention: req0 and req1 rise together, repeated twice -> grants in the order 0, 1, 0, 1.
REQ-042 Timeout: no eng_ack -> strobe dropped after 4096 cycles, done0 with err0=1, rdata unchanged.
REQ-043 Reset mid-BUSY: RESET=0 for 1 cycle -> next cycle IDLE, all outputs 0, no done pulse.
